// File: rtl/psum_drain_pkg.sv
// Shared types and constants for the psum drain path: FSM states, default lane
// widths and the psum-to-accumulator sign extension.
package psum_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } drain_state_e;

  localparam int unsigned PSUM_W_DEF = 52;
  localparam int unsigned ACC_W_DEF  = 64;

  function automatic logic [ACC_W_DEF-1:0] sext_psum(input logic [PSUM_W_DEF-1:0] p);
    return {{(ACC_W_DEF-PSUM_W_DEF){p[PSUM_W_DEF-1]}}, p};
  endfunction

endpackage

// File: rtl/psum_drain_acc_lane.sv
// Single-column accumulator: synchronous clear has priority over add; wraps modulo 2^ACC_W.
module psum_acc_lane #(
  parameter int unsigned ACC_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + addend;
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Accumulates psum rows from the systolic array over a programmed number of
// passes, then streams one accumulated column per beat over valid/ready.
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 8,
  parameter int unsigned PSUM_W     = PSUM_W_DEF,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned PASS_W     = 8,
  localparam int unsigned CW        = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PASS_W-1:0]            num_passes,
  input  logic                         psums_valid,
  input  logic [ARRAY_SIZE*PSUM_W-1:0] psums,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_data,
  output logic [CW-1:0]                out_col,
  output logic                         out_last,
  output logic                         done,
  output logic                         overrun
);

  localparam logic [CW-1:0] LAST_COL = CW'(ARRAY_SIZE - 1);

  drain_state_e      state_q, state_d;
  logic [PASS_W-1:0] passes_q;
  logic [CW-1:0]     col_q;
  logic              done_q, overrun_q;

  logic clr_acc, acc_en, load_passes, dec_passes;
  logic col_inc, col_clr, done_d, set_ovr, clr_ovr;

  logic [ACC_W-1:0] acc_q [ARRAY_SIZE];

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [PSUM_W-1:0] lane;
    logic [ACC_W-1:0]  addend;

    assign lane = psums[i*PSUM_W +: PSUM_W];

    if (PSUM_W == PSUM_W_DEF && ACC_W == ACC_W_DEF) begin : g_pkg_ext
      assign addend = sext_psum(lane);
    end else begin : g_cast_ext
      assign addend = ACC_W'(signed'(lane));
    end

    psum_acc_lane #(.ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr_acc),
      .en     (acc_en),
      .addend (addend),
      .acc    (acc_q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_acc     = 1'b0;
    acc_en      = 1'b0;
    load_passes = 1'b0;
    dec_passes  = 1'b0;
    col_inc     = 1'b0;
    col_clr     = 1'b0;
    done_d      = 1'b0;
    set_ovr     = 1'b0;
    clr_ovr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A row coinciding with start is the array flushing; drop it silently.
        if (start) begin
          state_d     = ACCUM;
          clr_acc     = 1'b1;
          load_passes = 1'b1;
          clr_ovr     = 1'b1;
        end else if (psums_valid) begin
          set_ovr = 1'b1;
        end
      end
      ACCUM: begin
        if (psums_valid) begin
          acc_en     = 1'b1;
          dec_passes = 1'b1;
          if (passes_q == PASS_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (psums_valid) begin
          set_ovr = 1'b1;
        end
        if (out_ready) begin
          if (col_q == LAST_COL) begin
            state_d = IDLE;
            col_clr = 1'b1;
            done_d  = 1'b1;
          end else begin
            col_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      passes_q  <= '0;
      col_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load_passes) begin
        passes_q <= (num_passes == '0) ? PASS_W'(1) : num_passes;
      end else if (dec_passes) begin
        passes_q <= passes_q - PASS_W'(1);
      end

      if (col_clr) begin
        col_q <= '0;
      end else if (col_inc) begin
        col_q <= col_q + CW'(1);
      end

      done_q <= done_d;

      if (clr_ovr) begin
        overrun_q <= 1'b0;
      end else if (set_ovr) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DRAIN);
  assign out_col   = col_q;
  assign out_last  = out_valid && (col_q == LAST_COL);
  assign out_data  = out_valid ? acc_q[col_q] : '0;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_psum_drain.sv
// Randomized self-checking bench for psum_drain against a column-sum reference model.
module tb_psum_drain;

  localparam int N      = 8;
  localparam int PW     = 52;
  localparam int AW     = 64;
  localparam int PASS_W = 13;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [PASS_W-1:0] num_passes = '0;
  logic              psums_valid = 1'b0;
  logic [N*PW-1:0]   psums = '0;
  logic              busy, out_valid, out_last, done, overrun;
  logic              out_ready = 1'b0;
  logic [AW-1:0]     out_data;
  logic [2:0]        out_col;

  psum_drain #(
    .ARRAY_SIZE (N),
    .PSUM_W     (PW),
    .ACC_W      (AW),
    .PASS_W     (PASS_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_passes  (num_passes),
    .psums_valid (psums_valid),
    .psums       (psums),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_col     (out_col),
    .out_last    (out_last),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per-column running sums and expected overrun flag.
  logic [AW-1:0] exp_m [N];
  logic          ovr_m;
  logic [PW-1:0] row [N];
  logic [AW-1:0] first_beat;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] widen(input logic [PW-1:0] v);
    logic signed [PW-1:0] s;
    longint               l;
    s = v;
    l = s;
    return l;
  endfunction

  task automatic pack_row();
    for (int i = 0; i < N; i++) psums[i*PW +: PW] = row[i];
  endtask

  task automatic rand_row();
    for (int i = 0; i < N; i++) row[i] = PW'({$urandom, $urandom});
  endtask

  task automatic do_start(input int n, input bit with_row);
    start      = 1'b1;
    num_passes = PASS_W'(n);
    if (with_row) begin
      rand_row();
      pack_row();
      psums_valid = 1'b1;
    end
    for (int i = 0; i < N; i++) exp_m[i] = '0;
    ovr_m = 1'b0;
    step();
    start       = 1'b0;
    psums_valid = 1'b0;
  endtask

  // Sends the current contents of row[] as one valid beat and folds it into the model.
  task automatic send_row();
    pack_row();
    psums_valid = 1'b1;
    for (int i = 0; i < N; i++) exp_m[i] = exp_m[i] + widen(row[i]);
    step();
    psums_valid = 1'b0;
  endtask

  task automatic send_rand_rows(input int n);
    for (int p = 0; p < n; p++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      rand_row();
      send_row();
    end
  endtask

  // mode: 0 always ready, 1 pattern 1,0,0,1, 2 random. Stops after 'stop' transfers.
  task automatic drain(input int mode, input int stop, input bit inject);
    int ncol;
    int cyc;
    bit rdy;
    ncol = 0;
    cyc  = 0;
    while (ncol < stop && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = $urandom_range(0, 1) == 1;
      endcase
      out_ready = rdy;
      if (inject && cyc == 1) begin
        rand_row();
        pack_row();
        psums_valid = 1'b1;
        ovr_m       = 1'b1;
      end else begin
        psums_valid = 1'b0;
      end
      check_eq("beat_valid", out_valid, 1);
      check_eq("beat_col", out_col, ncol);
      check_eq("beat_data", out_data, exp_m[ncol]);
      check_eq("beat_last", out_last, ncol == N - 1);
      check_eq("beat_done", done, 0);
      if (ncol == 0) first_beat = out_data;
      step();
      if (rdy) ncol++;
      cyc++;
    end
    out_ready   = 1'b0;
    psums_valid = 1'b0;
    if (cyc >= 200) check_eq("drain_timeout", cyc, 0);
    if (stop == N) begin
      check_eq("done_pulse", done, 1);
      check_eq("valid_drop", out_valid, 0);
      check_eq("busy_drop", busy, 0);
      step();
      check_eq("done_single", done, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ovr_m = 1'b0;
    for (int i = 0; i < N; i++) exp_m[i] = '0;
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ovr", overrun, 0);
    check_eq("rst_col", out_col, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_data", out_data, 0);
    rst = 1'b0;
    step();

    // Single pass, lane i = i+1, always ready.
    do_start(1, 0);
    check_eq("busy_accum", busy, 1);
    for (int i = 0; i < N; i++) row[i] = PW'(i + 1);
    send_row();
    drain(0, N, 0);
    check_eq("single_col0", first_beat, 64'd1);

    // Multi-pass signed accumulation on lane 0.
    do_start(3, 0);
    rand_row(); row[0] = -52'sd5; send_row();
    rand_row(); row[0] = 52'sd2;  send_row();
    rand_row(); row[0] = -52'sd1; send_row();
    drain(0, N, 0);
    check_eq("signed_col0", first_beat, 64'hFFFF_FFFF_FFFF_FFFC);

    // Backpressure pattern 1,0,0,1.
    do_start(2, 0);
    send_rand_rows(2);
    drain(1, N, 0);

    // Overrun during DRAIN: sticky past done, cleared by next start.
    do_start(1, 0);
    send_rand_rows(1);
    drain(2, N, 1);
    check_eq("ovr_after_done", overrun, 1);
    do_start(1, 0);
    check_eq("ovr_cleared", overrun, 0);
    send_rand_rows(1);
    drain(0, N, 0);

    // Row in IDLE without start sets overrun.
    rand_row();
    pack_row();
    psums_valid = 1'b1;
    step();
    psums_valid = 1'b0;
    check_eq("ovr_idle_row", overrun, 1);

    // start with a coincident row: row dropped, overrun cleared and not re-set.
    do_start(1, 1);
    check_eq("ovr_start_row", overrun, 0);
    send_rand_rows(1);
    drain(0, N, 0);

    // num_passes = 0 behaves as 1.
    do_start(0, 0);
    send_rand_rows(1);
    check_eq("np0_drain", out_valid, 1);
    drain(0, N, 0);

    // start during ACCUM is ignored.
    do_start(2, 0);
    send_rand_rows(1);
    start      = 1'b1;
    num_passes = PASS_W'(1);
    step();
    start = 1'b0;
    check_eq("start_ignored", out_valid, 0);
    send_rand_rows(1);
    drain(0, N, 0);

    // Large-count wrap check: (2^51-1) * 4096.
    do_start(4096, 0);
    for (int i = 0; i < N; i++) row[i] = 52'h7_FFFF_FFFF_FFFF;
    for (int p = 0; p < 4096; p++) send_row();
    drain(0, N, 0);
    check_eq("big_sum", first_beat, 64'h7FFF_FFFF_FFFF_F000);

    // Reset mid-DRAIN after three beats, then a fresh run.
    do_start(2, 0);
    send_rand_rows(2);
    drain(0, 3, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_col", out_col, 0);
    #2 rst = 1'b0;
    step();
    check_eq("arst_no_done", done, 0);
    do_start(1, 0);
    send_rand_rows(1);
    drain(0, N, 0);

    // Randomized runs.
    for (int t = 0; t < 20; t++) begin
      int  n;
      bit  inj;
      n   = $urandom_range(0, 5);
      inj = ($urandom_range(0, 3) == 0);
      do_start(n, 0);
      send_rand_rows((n == 0) ? 1 : n);
      drain($urandom_range(0, 2), N, inj);
      check_eq("rand_ovr", overrun, ovr_m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
- Consumer end of the systolic array's psum output bus.
- Captures the ARRAY_SIZE-wide 52-bit psum row the array emits each valid cycle and accumulates it per column over a programmed number of passes (K-tiles).
- Then serialises the ARRAY_SIZE accumulated results, one column per beat, onto a valid/ready stream toward the output buffer.
- The array has no backpressure, so this block never stalls its input; it flags overruns instead.

Parameters:
- ARRAY_SIZE, 8, columns per psum row; also the number of output beats per result.
- PSUM_W, 52, width of one array psum lane.
- ACC_W, 64, accumulator and output word width; must be >= PSUM_W.
- PASS_W, 8, width of the pass-count field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches num_passes and clears accumulators.
- num_passes  in  PASS_W  psum rows to accumulate per result; 0 is treated as 1.
- psums_valid  in  1  psums carries a valid row this cycle.
- psums  in  ARRAY_SIZE*PSUM_W  packed psum row; lane i is bits [i*PSUM_W +: PSUM_W], two's complement.
- busy  out  1  high in ACCUM and DRAIN.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  ACC_W  accumulated result for column out_col.
- out_col  out  clog2(ARRAY_SIZE)  column index of the current beat.
- out_last  out  1  high on the column ARRAY_SIZE-1 beat.
- done  out  1  one-cycle pulse after the last beat is accepted.
- overrun  out  1  sticky error flag; cleared by start.

Behaviour:
- Reset values: state IDLE; all outputs 0; accumulators 0; pass counter 0; column counter 0.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - start -> ACCUM next cycle.
  - On start: accumulators cleared, passes_left loaded with max(num_passes, 1), overrun cleared.
- ACCUM:
  - Each psums_valid cycle: acc[i] <= acc[i] + sign_extend(psums lane i) to ACC_W, all lanes in parallel; passes_left decrements.
  - Arithmetic wraps modulo 2^ACC_W; no saturation.
  - When the valid that brings passes_left to 0 is taken -> DRAIN next cycle. out_valid is high that next cycle (1-cycle latency from the final psum row to the first beat).
- DRAIN:
  - out_valid=1; out_data=acc[col]; out_col=col; out_last=(col==ARRAY_SIZE-1).
  - Beat transfers when out_valid && out_ready; col increments on transfer.
  - out_data, out_col and out_last are held stable while out_valid && !out_ready.
  - On transfer of the last beat: -> IDLE, col <= 0, done pulses for exactly the next cycle, out_valid drops the same cycle done rises.
- psums_valid in IDLE or DRAIN: row dropped, accumulators untouched, overrun <= 1 (sticky).
- start while busy: ignored; no effect on state, counters or overrun.
- start and psums_valid in the same IDLE cycle: start is taken, the row is dropped and does not set overrun (the array pipeline may still be flushing).
- rst asserted mid-operation: immediately forces reset values, including mid-DRAIN; a partial stream is abandoned with no done pulse.
- busy is combinational from state (state != IDLE).

Decomposition:
- Shared package holds:
  - state enum (IDLE, ACCUM, DRAIN);
  - default widths PSUM_W=52, ACC_W=64 (same constants the array and fusion units use);
  - function sext_psum(PSUM_W -> ACC_W).
- One natural sub-module: psum_acc_lane, a single-column ACC_W accumulator with clear/enable/add. Instantiated ARRAY_SIZE times in a generate loop.
- FSM, counters and output mux stay in psum_drain.

Test Plan:
- Single pass: start with num_passes=1; one row with lane i = i+1; out_ready=1 -> 8 beats, out_data=1..8, out_col=0..7, out_last on beat 7, done one cycle after beat 7, first beat one cycle after the row.
- Multi-pass signed: num_passes=3; lane 0 rows = -5, +2, -1 (52-bit two's complement) -> out_data[col0] = 64'hFFFF_FFFF_FFFF_FFFC (-4); sign extension checked on ACC_W bits.
- Backpressure: out_ready toggled 1,0,0,1 repeating -> each beat held stable while stalled; exactly 8 transfers; no duplicate or skipped columns.
- Overrun: psums_valid asserted during DRAIN -> overrun=1 and accumulated outputs unchanged. overrun stays 1 after done and clears on the next start.
- Edge cases:
  - num_passes=0 behaves as 1.
  - Lane value 2^51-1 accumulated 4096 times -> exact result 4096*(2^51-1) mod 2^64.
  - start during ACCUM -> ignored.
- Reset mid-DRAIN: rst asserted after beat 3 -> out_valid, busy and done all 0 asynchronously. A following start/1-pass sequence yields fresh results with no stale accumulator values.
